// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// A three-state controller (IDLE -> EXEC -> RESP) accepts one operation at a
// time, registers its operands onto the ALU bus, captures the result and flags
// one cycle later, and holds them as a response until the consumer takes it.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; without it requester 0 has fixed priority.

module alu_arbiter (
    input  logic        clk,
    input  logic        reset,

    // Requester 0
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_op,

    // Requester 1
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_op,

    // Shared ALU
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_cntr,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carryout,
    input  logic        alu_negative,

    // Response
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    logic any_valid;
    logic grant_id;   // requester chosen this cycle (meaningful only when any_valid)
    logic accept;     // an operation is taken this cycle
    logic owner_id;   // requester owning the operation in flight

    assign any_valid = req0_valid | req1_valid;

`ifdef ALU_ARB_RR_EN
    // Requester granted at the most recent accept; resets to 1 so that
    // requester 0 wins the first contention.
    logic last_grant;

    // Round-robin choice: on contention favour whoever was not granted last.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = ~req0_valid;
        end
    end

    // Remember the winner of every accept for the next contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_id;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        grant_id = ~req0_valid;
    end
`endif

    // Handshakes are combinational; they are forced low while reset is high
    // because the synchronous reset has not yet been applied to the state.
    assign accept     = (state == IDLE) && any_valid && !reset;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;
    assign rsp_valid  = (state == RESP) && !reset;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before the edge.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: the default assignment up front keeps every path covered, so
        // no latch is inferred for state_next.
        state_next = state;
        unique case (state)
            IDLE: if (any_valid)              state_next = EXEC;
            EXEC:                             state_next = RESP;
            RESP: if (rsp_valid && rsp_ready) state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Operand bus: loaded only when an operation is accepted, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_cntr <= 2'b00;
            owner_id <= 1'b0;
        end else if (accept) begin
            alu_a    <= grant_id ? req1_a  : req0_a;
            alu_b    <= grant_id ? req1_b  : req0_b;
            alu_cntr <= grant_id ? req1_op : req0_op;
            owner_id <= grant_id;
        end
    end

    // Response capture at the end of EXEC; held through RESP until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data  <= '0;
            rsp_flags <= 4'b0000;
            rsp_id    <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data  <= alu_out;
            rsp_flags <= {alu_negative, alu_carryout, alu_overflow, alu_zero};
            rsp_id    <= owner_id;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level reference model (arbitration choice plus ALU result).
// The bench also plays the role of the shared ALU. Compile with
// ALU_ARB_RR_EN defined to check the round-robin build.

module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv  [2];
    logic [31:0] ra  [2];
    logic [31:0] rb  [2];
    logic [1:0]  rop [2];
    logic        req0_ready, req1_ready;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [1:0]  alu_cntr;
    logic        alu_zero, alu_overflow, alu_carryout, alu_negative;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;

    int n_vec = 0;
    int n_err = 0;
    bit last_g;     // model: requester granted at the last accept

    always #5 clk = ~clk;

    // Reference ALU: returns {negative, carryout, overflow, zero, result}.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        co, ov;
        co = 1'b0;
        ov = 1'b0;
        s  = '0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            default: begin
                r  = a - b;
                co = (a < b);
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
        endcase
        return {r[31], co, ov, (r == 32'd0), r};
    endfunction

    // The bench acts as the shared combinational ALU.
    logic [35:0] alu_bus;
    assign alu_bus      = alu_ref(alu_a, alu_b, alu_cntr);
    assign alu_out      = alu_bus[31:0];
    assign alu_zero     = alu_bus[32];
    assign alu_overflow = alu_bus[33];
    assign alu_carryout = alu_bus[34];
    assign alu_negative = alu_bus[35];

    alu_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (rv[0]),
        .req0_ready   (req0_ready),
        .req0_a       (ra[0]),
        .req0_b       (rb[0]),
        .req0_op      (rop[0]),
        .req1_valid   (rv[1]),
        .req1_ready   (req1_ready),
        .req1_a       (ra[1]),
        .req1_b       (rb[1]),
        .req1_op      (rop[1]),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cntr     (alu_cntr),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_carryout (alu_carryout),
        .alu_negative (alu_negative),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_flags    (rsp_flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        ra[r]  = a;
        rb[r]  = b;
        rop[r] = op;
        rv[r]  = 1'b1;
    endtask

    task automatic rand_req(input int r);
        logic [31:0] a;
        a = $urandom;
        set_req(r, a, ($urandom_range(0, 3) == 0) ? a : $urandom, 2'($urandom_range(0, 3)));
    endtask

    // One cycle with nothing requested: no handshake, no response.
    task automatic idle_cycle();
        @(negedge clk);
        check("idle_req0_ready", req0_ready, 1'b0);
        check("idle_req1_ready", req1_ready, 1'b0);
        check("idle_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    // Full transaction starting in an IDLE cycle with at least one request
    // valid. The response is held back for 'hold' cycles before being taken.
    // Returns one cycle after the response handshake (IDLE again).
    task automatic expect_txn(input int hold, input bit refill);
        int          g;
        logic [35:0] e;
        logic [31:0] ea, eb;
        logic [1:0]  eop;
        @(negedge clk);
        if (rv[0] && rv[1]) g = RR ? (last_g ? 0 : 1) : 0;
        else                g = rv[0] ? 0 : 1;
        check("accept_req0_ready", req0_ready, g == 0);
        check("accept_req1_ready", req1_ready, g == 1);
        ea     = ra[g];
        eb     = rb[g];
        eop    = rop[g];
        e      = alu_ref(ea, eb, eop);
        last_g = (g == 1);
        @(posedge clk); #1;
        if (refill) rand_req(g);
        else        rv[g] = 1'b0;
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("exec_req0_ready", req0_ready, 1'b0);
        check("exec_req1_ready", req1_ready, 1'b0);
        check("exec_rsp_valid", rsp_valid, 1'b0);
        check("exec_alu_a", alu_a, ea);
        check("exec_alu_b", alu_b, eb);
        check("exec_alu_cntr", alu_cntr, eop);
        @(posedge clk); #1;
        rsp_ready = (hold == 0);
        @(negedge clk);
        check("resp_valid", rsp_valid, 1'b1);
        check("resp_id", rsp_id, g == 1);
        check("resp_data", rsp_data, e[31:0]);
        check("resp_flags", rsp_flags, e[35:32]);
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            rsp_ready = (k == hold);
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_data", rsp_data, e[31:0]);
            check("hold_rsp_flags", rsp_flags, e[35:32]);
            check("hold_rsp_id", rsp_id, g == 1);
            check("hold_no_ready", {req0_ready, req1_ready}, 2'b00);
            check("hold_alu_a", alu_a, ea);
            check("hold_alu_cntr", alu_cntr, eop);
        end
        @(posedge clk); #1;
        rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_values();
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_cntr", alu_cntr, 2'b00);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_flags", rsp_flags, 4'b0000);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        // Reset held with both requesters valid: no handshake may escape.
        reset     = 1'b1;
        rsp_ready = 1'b1;
        last_g    = 1'b1;
        set_req(0, 32'h1, 32'h2, OP_ADD);
        set_req(1, 32'h3, 32'h4, OP_ADD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_reset_ready", {req0_ready, req1_ready}, 2'b00);
            check("in_reset_rsp_valid", rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_reset_values();
        check("post_reset_ready", {req0_ready, req1_ready}, 2'b00);
        @(posedge clk); #1;

        // Requester 0 alone: 5 + 3.
        set_req(0, 32'd5, 32'd3, OP_ADD);
        expect_txn(0, 1'b0);

        // Requester 1 alone: signed overflow into the sign bit.
        set_req(1, 32'h7FFF_FFFF, 32'd1, OP_ADD);
        expect_txn(0, 1'b0);

        // Equal operands subtracted: zero result.
        set_req(0, 32'h1234, 32'h1234, OP_SUB);
        expect_txn(1, 1'b0);

        // Rsp_ready high while idle has no effect.
        rsp_ready = 1'b1;
        idle_cycle();
        idle_cycle();

        // Sustained contention: four back-to-back operations, then drain.
        set_req(0, 32'hA5A5_0000, 32'h0F0F_0F0F, OP_OR);
        set_req(1, 32'hDEAD_BEEF, 32'hFFFF_0000, OP_AND);
        for (int i = 0; i < 4; i++) expect_txn(0, 1'b1);
        rv[0] = 1'b0;
        expect_txn(0, 1'b0);
        if (rv[1]) expect_txn(0, 1'b0);

        // Long back-pressure on the response.
        set_req(1, 32'h8000_0000, 32'h8000_0000, OP_ADD);
        set_req(0, 32'd7, 32'd9, OP_SUB);
        expect_txn(10, 1'b0);
        expect_txn(0, 1'b0);

        // Reset during EXEC discards the operation.
        set_req(1, 32'h0BAD_F00D, 32'h1111_1111, OP_ADD);
        @(negedge clk);
        check("rstexec_accept", req1_ready, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        rv[0] = 1'b1;
        @(negedge clk);
        check("rstexec_ready", {req0_ready, req1_ready}, 2'b00);
        check("rstexec_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        reset  = 1'b0;
        rv[0]  = 1'b0;
        rv[1]  = 1'b0;
        last_g = 1'b1;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) idle_cycle();

        // First contention after reset goes to requester 0 in both builds.
        set_req(0, 32'h0000_0001, 32'hFFFF_FFFF, OP_ADD);
        set_req(1, 32'h8000_0000, 32'h0000_0001, OP_SUB);
        expect_txn(0, 1'b0);
        expect_txn(0, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!rv[r] && ($urandom_range(0, 2) != 0)) rand_req(r);
            end
            if (!rv[0] && !rv[1]) idle_cycle();
            else expect_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req0_valid / req1_valid  input  1  requester n has an ALU operation pending.
REQ-004 req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-005 req0_a, req0_b / req1_a, req1_b  input  32  operands of requester n.
REQ-006 req0_op / req1_op  input  2  ALU control code of requester n, passed through unmodified.
REQ-007 alu_a, alu_b  output  32  registered operands to the shared ALU bus_a/bus_b.
REQ-008 alu_cntr  output  2  registered control code to the shared ALU.
REQ-009 alu_out  input  32  ALU result.
REQ-010 alu_zero, alu_overflow, alu_carryout, alu_negative  input  1  ALU flags.
REQ-011 rsp_valid  output  1  response holds a completed result.
REQ-012 rsp_ready  input  1  consumer takes the response.
REQ-013 rsp_id  output  1  requester that owns the response (0 or 1).
REQ-014 rsp_data  output  32  captured alu_out.
REQ-015 rsp_flags  output  4  captured {negative, carryout, overflow, zero}.

Function
REQ-016 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-017 IDLE: no reqn_valid -> stay IDLE; any reqn_valid -> grant one requester, assert only its reqn_ready combinationally that cycle, load its a/b/op into alu_a/alu_b/alu_cntr, record grant id, go EXEC.
REQ-018 reqn_ready SHALL be high only in IDLE, only for the granted requester, only when its reqn_valid is high.
REQ-019 At most one reqn_ready high per cycle; a requester not granted keeps valid/data stable and is not dropped.
REQ-020 EXEC: ALU operates combinationally on registered operands; at end of cycle capture alu_out into rsp_data, flags into rsp_flags, grant id into rsp_id; go RESP.
REQ-021 RESP: rsp_valid high; rsp_data/rsp_flags/rsp_id stable until rsp_ready sampled high; on rsp_valid && rsp_ready go IDLE.
REQ-022 Latency: request accepted in cycle N -> rsp_valid first high in cycle N+2; minimum issue interval 3 cycles.
REQ-023 rsp_ready held low indefinitely -> block stays in RESP, no new accepts, alu_* outputs unchanged.
REQ-024 rsp_ready high while not in RESP has no effect.
REQ-025 alu_a/alu_b/alu_cntr change only on an IDLE accept; hold otherwise.
REQ-026 Flags and data are captured verbatim; no arithmetic or width change inside the block.
REQ-027 Arbitration policy per Configuration; single valid requester always granted regardless of policy.

Reset
REQ-028 reset high at a rising edge -> state IDLE, in-flight operation discarded with no response, rsp_valid 0.
REQ-029 Reset values: alu_a 0, alu_b 0, alu_cntr 2'b00, rsp_data 0, rsp_flags 4'b0000, rsp_id 0, last-grant register 1 (requester 0 wins first contention).
REQ-030 While reset high: req0_ready = req1_ready = 0, rsp_valid = 0.

Configuration
REQ-031 Macro ALU_ARB_RR_EN defined -> round-robin: on simultaneous valid, grant the requester not granted last; last-grant register updates on every accept.
REQ-032 ALU_ARB_RR_EN undefined -> fixed priority: requester 0 always wins contention; last-grant register absent or unused.

Verification
REQ-033 Reset, then req0 only: a=5, b=3, op=add code -> req0_ready cycle N, rsp_valid cycle N+2, rsp_id 0, rsp_data 8, rsp_flags 0000.
REQ-034 req1 only: a=0x7FFFFFFF, b=1, add -> rsp_id 1, rsp_data 0x80000000, negative and overflow set per ALU.
REQ-035 Both valid continuously, 4 ops, RR_EN defined -> grants 0,1,0,1; RR_EN undefined -> grants 0,0,0,0 with req1 starved, req1 data stable.
REQ-036 rsp_ready low 10 cycles in RESP -> rsp_valid held, rsp_data unchanged, no reqn_ready; rsp_ready high -> IDLE next cycle, new accept the cycle after.
REQ-037 reset asserted in EXEC -> next cycle IDLE, rsp_valid never asserts for that op, all outputs at reset values.
REQ-038 a=b=0x1234, sub code -> rsp_data 0, zero flag set.
